fc_dot_engine: RTL and testbench

FC_DOT_ENGINE -- requirements
Module: fc_dot_engine

---
 rtl/fc_dot_engine_if.sv | 62 ++++++
 rtl/fc_dot_engine.sv | 159 +++++++++++++++
 tb/tb_fc_dot_engine.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_dot_engine_if.sv
// ---------------------------------------------------------------------------
// fc_dot_engine_if
//
// Purpose: bundles the request, vector/weight store and result signals of
// the fully-connected dot-product engine into one interface.
//
// Signals:
//   start       request one dot-product run            (master -> slave)
//   bias        signed bias, taken with accepted start (master -> slave)
//   vec_data    unsigned vector element at addr_vector (master -> slave)
//   w_data      signed weight at addr_vector           (master -> slave)
//   addr_vector registered vector/weight store address (slave -> master)
//   busy        high while elements are being consumed (slave -> master)
//   done        one-cycle pulse marking a valid result (slave -> master)
//   result      signed dot product plus bias           (slave -> master)
//   class_out   1 when result >= 0                     (slave -> master)
//
// Modports: master = requester / memory side, slave = the engine.
// ---------------------------------------------------------------------------
interface fc_dot_engine_if #(
  parameter int ADDR_BITS  = 6,
  parameter int DATA_WIDTH = 4,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int BIAS_WIDTH = 16
) ();

  logic                         start;
  logic signed [BIAS_WIDTH-1:0] bias;
  logic [ADDR_BITS-1:0]         addr_vector;
  logic [DATA_WIDTH-1:0]        vec_data;
  logic signed [W_WIDTH-1:0]    w_data;
  logic                         busy;
  logic                         done;
  logic signed [ACC_WIDTH-1:0]  result;
  logic                         class_out;

  modport master (
    output start,
    output bias,
    output vec_data,
    output w_data,
    input  addr_vector,
    input  busy,
    input  done,
    input  result,
    input  class_out
  );

  modport slave (
    input  start,
    input  bias,
    input  vec_data,
    input  w_data,
    output addr_vector,
    output busy,
    output done,
    output result,
    output class_out
  );

endinterface

// File: rtl/fc_dot_engine.sv
// ---------------------------------------------------------------------------
// fc_dot_engine
//
// Purpose: computes one fully-connected neuron output
//   result = bias + sum_{i=0}^{VEC_LEN-1} vec[i] * w[i]
// by walking addr_vector over the vector and weight stores, one element per
// clock, and classifies the result as healthy (class_out = 1) when it is
// non-negative.
//
// Ports:
//   clk     single clock, rising edge
//   rst     synchronous active-high reset
//   io_bus  fc_dot_engine_if.slave: start/bias request, addr_vector out,
//           vec_data/w_data in (combinational store reads), busy/done/
//           result/class_out out. All outputs are registered.
//
// Timing: start accepted at edge k -> busy for VEC_LEN cycles, done pulse in
// the cycle after edge k+VEC_LEN, FSM back in IDLE one cycle later.
// ---------------------------------------------------------------------------
module fc_dot_engine #(
  parameter int VEC_LEN    = 64,
  parameter int ADDR_BITS  = 6,
  parameter int DATA_WIDTH = 4,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int BIAS_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  fc_dot_engine_if.slave   io_bus
);

  // Product of a zero-extended element and a signed weight needs one extra
  // bit on top of the two operand widths.
  localparam int PROD_WIDTH = DATA_WIDTH + W_WIDTH + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(VEC_LEN - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_nextState;

  logic [ADDR_BITS-1:0]         r_addr;
  logic [ADDR_BITS-1:0]         w_nextAddr;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_nextAcc;
  logic signed [ACC_WIDTH-1:0]  r_result;
  logic signed [ACC_WIDTH-1:0]  w_nextResult;
  logic                         r_busy;
  logic                         w_nextBusy;
  logic                         r_done;
  logic                         w_nextDone;
  logic                         r_classOut;
  logic                         w_nextClassOut;

  logic signed [PROD_WIDTH-1:0] w_vecExt;
  logic signed [PROD_WIDTH-1:0] w_weightExt;
  logic signed [PROD_WIDTH-1:0] w_product;
  logic signed [ACC_WIDTH-1:0]  w_productExt;
  logic signed [ACC_WIDTH-1:0]  w_biasExt;
  logic signed [ACC_WIDTH-1:0]  w_sum;

  // Datapath: the element is unsigned, so it is zero-extended before the
  // signed multiply; both operands are widened to the product width so the
  // multiply is exact in PROD_WIDTH bits. The product and the bias are then
  // sign-extended to the accumulator width, where sums wrap in two's
  // complement.
  assign w_vecExt     = {{(PROD_WIDTH - DATA_WIDTH){1'b0}}, io_bus.vec_data};
  assign w_weightExt  = {{(PROD_WIDTH - W_WIDTH){io_bus.w_data[W_WIDTH-1]}}, io_bus.w_data};
  assign w_product    = w_vecExt * w_weightExt;
  assign w_productExt = {{(ACC_WIDTH - PROD_WIDTH){w_product[PROD_WIDTH-1]}}, w_product};
  assign w_biasExt    = {{(ACC_WIDTH - BIAS_WIDTH){io_bus.bias[BIAS_WIDTH-1]}}, io_bus.bias};
  assign w_sum        = r_acc + w_productExt;

  // State and output registers. Reset wins over everything, including a
  // start in the same cycle, and abandons any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_classOut <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_addr     <= w_nextAddr;
      r_acc      <= w_nextAcc;
      r_result   <= w_nextResult;
      r_busy     <= w_nextBusy;
      r_done     <= w_nextDone;
      r_classOut <= w_nextClassOut;
    end
  end

  // Next-state and next-output logic. Everything holds by default except
  // done, which is a single-cycle pulse. start and bias are only looked at
  // in IDLE, so a request during RUN or DONE is simply dropped.
  always_comb begin
    w_nextState    = r_state;
    w_nextAddr     = r_addr;
    w_nextAcc      = r_acc;
    w_nextResult   = r_result;
    w_nextBusy     = r_busy;
    w_nextDone     = 1'b0;
    w_nextClassOut = r_classOut;

    case (r_state)
      IDLE: begin
        w_nextAddr = '0;
        if (io_bus.start) begin
          w_nextState = RUN;
          w_nextAcc   = w_biasExt;
          w_nextBusy  = 1'b1;
        end
      end

      RUN: begin
        if (r_addr == LAST_ADDR) begin
          // Last element: the final product goes straight into the result
          // register rather than through the accumulator, saving a cycle.
          w_nextState    = DONE;
          w_nextResult   = w_sum;
          w_nextClassOut = ~w_sum[ACC_WIDTH-1];
          w_nextDone     = 1'b1;
          w_nextBusy     = 1'b0;
          w_nextAddr     = '0;
        end else begin
          w_nextAcc  = w_sum;
          w_nextAddr = r_addr + ADDR_ONE;
        end
      end

      DONE: begin
        w_nextState = IDLE;
        w_nextAddr  = '0;
      end

      default: begin
        w_nextState = IDLE;
        w_nextAddr  = '0;
        w_nextBusy  = 1'b0;
      end
    endcase
  end

  assign io_bus.addr_vector = r_addr;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.result      = r_result;
  assign io_bus.class_out   = r_classOut;

endmodule

// File: tb/tb_fc_dot_engine.sv
// ---------------------------------------------------------------------------
// tb_fc_dot_engine
//
// Purpose: self-checking bench for fc_dot_engine. Models the vector and
// weight stores as arrays read combinationally at addr_vector, and computes
// expected results as plain integer sums of vec[i]*w[i] plus bias.
// ---------------------------------------------------------------------------
module tb_fc_dot_engine;

  localparam int VEC_LEN    = 64;
  localparam int ADDR_BITS  = 6;
  localparam int DATA_WIDTH = 4;
  localparam int W_WIDTH    = 8;
  localparam int ACC_WIDTH  = 20;
  localparam int BIAS_WIDTH = 16;

  typedef struct {
    string name;
    int    vecKind;
    int    vecVal;
    int    wKind;
    int    wVal;
    int    biasVal;
    int    expResult;
    int    expClass;
  } vecRec_t;

  logic clk = 1'b0;
  logic rst;

  logic [DATA_WIDTH-1:0]     vecMem [VEC_LEN];
  logic signed [W_WIDTH-1:0] wMem   [VEC_LEN];

  int nCompared   = 0;
  int nMismatched = 0;
  int lastResult  = 0;

  fc_dot_engine_if #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH),
    .W_WIDTH   (W_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .BIAS_WIDTH(BIAS_WIDTH)
  ) busIf ();

  fc_dot_engine #(
    .VEC_LEN   (VEC_LEN),
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH),
    .W_WIDTH   (W_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .BIAS_WIDTH(BIAS_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(busIf.slave)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Vector and weight stores answer combinationally at the engine address.
  assign busIf.vec_data = vecMem[busIf.addr_vector];
  assign busIf.w_data   = wMem[busIf.addr_vector];

  // One comparison: counted, and reported on a line of its own if wrong.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference dot product: integer sum, then wrapped to the result width.
  function automatic int refModel(input int b);
    longint sum;
    logic signed [ACC_WIDTH-1:0] wrapped;
    sum = longint'(b);
    for (int i = 0; i < VEC_LEN; i++)
      sum += longint'(vecMem[i]) * longint'(wMem[i]);
    wrapped = sum[ACC_WIDTH-1:0];
    return int'(wrapped);
  endfunction

  // vecKind 0: constant vecVal; 1: i mod 16.  wKind 0: constant wVal;
  // 1: 2 on even index, -1 on odd index.
  task automatic fillPattern(input int vecKind, input int vecVal, input int wKind, input int wVal);
    for (int i = 0; i < VEC_LEN; i++) begin
      vecMem[i] = (vecKind == 1) ? DATA_WIDTH'(i % 16) : DATA_WIDTH'(vecVal);
      wMem[i]   = (wKind == 1) ? ((i % 2 == 0) ? W_WIDTH'(2) : W_WIDTH'(-1)) : W_WIDTH'(wVal);
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < VEC_LEN; i++) begin
      vecMem[i] = DATA_WIDTH'($urandom_range(0, 15));
      wMem[i]   = W_WIDTH'($urandom_range(0, 255));
    end
  endtask

  // Pulses start for one cycle, then watches the run cycle by cycle.
  // Observation cyc = n is taken just after edge k+n, where k is the edge
  // that accepted start. Optionally pulses start again (different bias) at
  // observation glitchAt to show it is ignored mid-run.
  task automatic applyStimulus(input int b, input int glitchAt, input int glitchBias,
                               output int doneCycle, output int busyCycles, output bit addrOk);
    doneCycle  = -1;
    busyCycles = 0;
    addrOk     = 1'b1;
    @(negedge clk);
    busIf.start = 1'b1;
    busIf.bias  = BIAS_WIDTH'(b);
    @(negedge clk);
    busIf.start = 1'b0;
    for (int cyc = 0; cyc <= VEC_LEN + 8; cyc++) begin
      if (cyc == 32)
        checkOutput("resultHeldDuringRun", int'($signed(busIf.result)), lastResult);
      if (busIf.busy) begin
        busyCycles++;
        if (int'(busIf.addr_vector) != cyc) addrOk = 1'b0;
      end
      if (busIf.done) begin
        doneCycle = cyc;
        break;
      end
      if (cyc == glitchAt) begin
        busIf.start = 1'b1;
        busIf.bias  = BIAS_WIDTH'(glitchBias);
      end else begin
        busIf.start = 1'b0;
      end
      @(negedge clk);
    end
    busIf.start = 1'b0;
  endtask

  // Full run with every run-level check, then checks the pulse is one cycle.
  task automatic checkRun(input string name, input int b, input int glitchAt,
                          input int glitchBias, input int expResult);
    int doneCycle;
    int busyCycles;
    bit addrOk;
    applyStimulus(b, glitchAt, glitchBias, doneCycle, busyCycles, addrOk);
    checkOutput({name, " doneLatency"}, doneCycle, VEC_LEN);
    checkOutput({name, " busyCycles"}, busyCycles, VEC_LEN);
    checkOutput({name, " addrSequence"}, int'(addrOk), 1);
    checkOutput({name, " result"}, int'($signed(busIf.result)), expResult);
    checkOutput({name, " classOut"}, int'(busIf.class_out), (expResult >= 0) ? 1 : 0);
    @(negedge clk);
    checkOutput({name, " doneOneCycle"}, int'(busIf.done), 0);
    checkOutput({name, " resultHeldIdle"}, int'($signed(busIf.result)), expResult);
    lastResult = expResult;
  endtask

  vecRec_t vectors [6];

  initial begin
    int b;
    int exp;
    int doneAt [$];
    int doneSeen;
    logic signed [BIAS_WIDTH-1:0] rb;

    vectors[0] = '{"allOnes",      0,  1, 0,    1,      0,      64, 1};
    vectors[1] = '{"mostNegative", 0, 15, 0, -128, -32768, -155648, 0};
    vectors[2] = '{"mostPositive", 0, 15, 0,  127,  32767,  154687, 1};
    vectors[3] = '{"rampAltW",     1,  0, 1,    0,      5,     197, 1};
    vectors[4] = '{"zeroResult",   0,  0, 0,   77,      0,       0, 1};
    vectors[5] = '{"minusOne",     0,  0, 0,   77,     -1,      -1, 0};

    rst         = 1'b1;
    busIf.start = 1'b0;
    busIf.bias  = '0;
    fillPattern(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset addr", int'(busIf.addr_vector), 0);
    checkOutput("reset busy", int'(busIf.busy), 0);
    checkOutput("reset done", int'(busIf.done), 0);
    checkOutput("reset result", int'($signed(busIf.result)), 0);
    checkOutput("reset classOut", int'(busIf.class_out), 1);
    rst = 1'b0;

    $display("[TB] directed vector table");
    foreach (vectors[i]) begin
      fillPattern(vectors[i].vecKind, vectors[i].vecVal, vectors[i].wKind, vectors[i].wVal);
      checkRun(vectors[i].name, vectors[i].biasVal, -1, 0, vectors[i].expResult);
      checkOutput({vectors[i].name, " classTable"}, int'(busIf.class_out), vectors[i].expClass);
    end

    $display("[TB] randomized runs against reference model");
    for (int r = 0; r < 5; r++) begin
      fillRandom();
      rb = BIAS_WIDTH'($urandom);
      b  = int'(rb);
      checkRun((r == 2) ? "randomGlitch" : "random", b, (r == 2) ? 20 : -1,
               (b > 0) ? -1000 : 1000, refModel(b));
    end

    $display("[TB] start held high");
    fillRandom();
    rb  = BIAS_WIDTH'($urandom);
    b   = int'(rb);
    exp = refModel(b);
    @(negedge clk);
    busIf.start = 1'b1;
    busIf.bias  = BIAS_WIDTH'(b);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (busIf.done) begin
        doneAt.push_back(cyc);
        checkOutput("heldStart result", int'($signed(busIf.result)), exp);
      end
    end
    busIf.start = 1'b0;
    checkOutput("heldStart doneCount", doneAt.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("heldStart doneOffset", (i < doneAt.size()) ? doneAt[i] : -1,
                  VEC_LEN + i * (VEC_LEN + 2));
    doneSeen = 0;
    for (int n = 0; n < VEC_LEN + 10; n++) begin
      @(negedge clk);
      if (busIf.done) begin
        doneSeen = 1;
        break;
      end
    end
    checkOutput("heldStart drainDone", doneSeen, 1);
    @(negedge clk);
    lastResult = exp;

    $display("[TB] reset in the middle of a run");
    fillRandom();
    rb = BIAS_WIDTH'($urandom);
    b  = int'(rb);
    @(negedge clk);
    busIf.start = 1'b1;
    busIf.bias  = BIAS_WIDTH'(b);
    @(negedge clk);
    busIf.start = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midReset addrBefore", int'(busIf.addr_vector), 30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset busy", int'(busIf.busy), 0);
    checkOutput("midReset done", int'(busIf.done), 0);
    checkOutput("midReset addr", int'(busIf.addr_vector), 0);
    checkOutput("midReset result", int'($signed(busIf.result)), 0);
    checkOutput("midReset classOut", int'(busIf.class_out), 1);
    doneSeen = 0;
    for (int n = 0; n < VEC_LEN + 10; n++) begin
      @(negedge clk);
      if (busIf.done) doneSeen++;
    end
    checkOutput("midReset noDone", doneSeen, 0);
    lastResult = 0;

    // Reset and start together: reset must win.
    busIf.start = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    busIf.start = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
    checkOutput("resetOverStart busy", int'(busIf.busy), 0);

    checkRun("afterReset", b, -1, 0, refModel(b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    nMismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
